// File: rtl/clock_set_pkg.sv
// clock_set_pkg: shared state codes, BCD limits and field masks for the clock-set controller
package clock_set_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    SET_S = 2'b11
  } state_e;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  localparam logic [2:0] FLD_NONE = 3'b000;
  localparam logic [2:0] FLD_HOUR = 3'b100;
  localparam logic [2:0] FLD_MIN  = 3'b010;
  localparam logic [2:0] FLD_SEC  = 3'b001;
endpackage

// File: rtl/bcd2_updown.sv
// bcd2_updown: combinational two-digit BCD step up/down with wrap at MAX; malformed input snaps to 00/MAX
module bcd2_updown import clock_set_pkg::*; #(
  parameter logic [7:0] MAX = HOUR_MAX
) (
  input  logic [7:0] value_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] next_o
);
  logic       valid;
  logic [7:0] up;
  logic [7:0] dn;
  assign valid  = value_i[7:4] <= 4'd9 && value_i[3:0] <= 4'd9 && value_i <= MAX;
  assign up     = (!valid || value_i == MAX) ? 8'h00 :
                  value_i[3:0] == 4'd9 ? {value_i[7:4] + 4'd1, 4'd0} : value_i + 8'd1;
  assign dn     = (!valid || value_i == 8'h00) ? MAX :
                  value_i[3:0] == 4'd0 ? {value_i[7:4] - 4'd1, 4'd9} : value_i - 8'd1;
  assign next_o = (inc_i == dec_i) ? value_i : inc_i ? up : dn;
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: HH:MM:SS set-mode sequencer; CLKSET_TIMEOUT_EN adds an idle abandon timer
module clock_set_controller import clock_set_pkg::*; #(
  parameter int BLINK_DIV = 25_000_000
`ifdef CLKSET_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 500_000_000
`endif
) (
  input  logic       clkinput,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic       run_en,
  output logic       load,
  output logic [7:0] set_hour,
  output logic [7:0] set_min,
  output logic [7:0] set_sec,
  output logic [2:0] blink_sel,
  output logic       blink_phase,
  output logic [1:0] mode
);
  localparam int BW = $clog2(BLINK_DIV + 1);
  state_e        state_q;
  logic          run_en_q;
  logic          load_q;
  logic [7:0]    hour_q, min_q, sec_q;
  logic [7:0]    hour_d, min_d, sec_d;
  logic [2:0]    sel_q;
  logic          phase_q;
  logic [BW-1:0] blink_q;
  logic          edit;
  logic          blink_wrap;
  logic          timeout;
  assign edit       = btn_inc | btn_dec;
  assign blink_wrap = blink_q == BW'(BLINK_DIV - 1);

  bcd2_updown #(.MAX(HOUR_MAX))   u_hour (.value_i(hour_q), .inc_i(btn_inc), .dec_i(btn_dec), .next_o(hour_d));
  bcd2_updown #(.MAX(MINSEC_MAX)) u_min  (.value_i(min_q),  .inc_i(btn_inc), .dec_i(btn_dec), .next_o(min_d));
  bcd2_updown #(.MAX(MINSEC_MAX)) u_sec  (.value_i(sec_q),  .inc_i(btn_inc), .dec_i(btn_dec), .next_o(sec_d));

`ifdef CLKSET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_q;
  assign timeout = state_q != RUN && !btn_mode && !edit && idle_q == TW'(TIMEOUT_CYC - 1);
  // idle timer: counts button-free cycles while editing, zero in RUN
  always_ff @(posedge clkinput or negedge reset)
    if (!reset) idle_q <= '0;
    else        idle_q <= (state_q == RUN || btn_mode || edit || timeout) ? '0 : idle_q + 1'b1;
`else
  assign timeout = 1'b0;
`endif

  // mode FSM with shadow registers, blink timer and registered strobes
  always_ff @(posedge clkinput or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      run_en_q <= 1'b1;
      load_q   <= 1'b0;
      hour_q   <= 8'h00;
      min_q    <= 8'h00;
      sec_q    <= 8'h00;
      sel_q    <= FLD_NONE;
      phase_q  <= 1'b0;
      blink_q  <= '0;
    end else begin
      load_q  <= 1'b0;
      blink_q <= (edit || blink_wrap) ? '0 : blink_q + 1'b1;
      phase_q <= edit ? 1'b0 : phase_q ^ blink_wrap;
      if (timeout) begin
        state_q  <= RUN;
        run_en_q <= 1'b1;
        sel_q    <= FLD_NONE;
        blink_q  <= '0;
        phase_q  <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            blink_q <= '0;
            phase_q <= 1'b0;
            if (btn_mode) begin
              hour_q   <= cur_hour;
              min_q    <= cur_min;
              sec_q    <= cur_sec;
              state_q  <= SET_H;
              run_en_q <= 1'b0;
              sel_q    <= FLD_HOUR;
            end
          end
          SET_H: if (btn_mode) begin
            state_q <= SET_M;
            sel_q   <= FLD_MIN;
          end else hour_q <= hour_d;
          SET_M: if (btn_mode) begin
            state_q <= SET_S;
            sel_q   <= FLD_SEC;
          end else min_q <= min_d;
          default: if (btn_mode) begin
            state_q  <= RUN;
            load_q   <= 1'b1;
            run_en_q <= 1'b1;
            sel_q    <= FLD_NONE;
            blink_q  <= '0;
            phase_q  <= 1'b0;
          end else sec_q <= sec_d;
        endcase
      end
    end
  end

  assign mode        = state_q;
  assign run_en      = run_en_q;
  assign load        = load_q;
  assign set_hour    = hour_q;
  assign set_min     = min_q;
  assign set_sec     = sec_q;
  assign blink_sel   = sel_q;
  assign blink_phase = phase_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: vector table, directed corner cases and random run against a decimal reference model
module tb_clock_set_controller;
  localparam int BLINK_DIV   = 4;
  localparam int TIMEOUT_CYC = 100;

  logic       clkinput = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec;
  logic [7:0] cur_hour, cur_min, cur_sec;
  logic       run_en, load, blink_phase;
  logic [7:0] set_hour, set_min, set_sec;
  logic [2:0] blink_sel;
  logic [1:0] mode;

  clock_set_controller #(
    .BLINK_DIV(BLINK_DIV)
`ifdef CLKSET_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) dut (
    .clkinput(clkinput), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec), .run_en(run_en), .load(load),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec), .blink_sel(blink_sel),
    .blink_phase(blink_phase), .mode(mode)
  );

  always #5 clkinput = ~clkinput;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: state index, decimal-checked BCD fields, cycles since blink clear
  int         m_state, m_k, m_idle;
  bit         m_run, m_load;
  logic [7:0] m_h, m_m, m_s;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(int d);
    return 8'((d / 10) * 16 + d % 10);
  endfunction

  function automatic logic [7:0] step(logic [7:0] v, int mx, bit up);
    int t = int'(v[7:4]);
    int o = int'(v[3:0]);
    int d = t * 10 + o;
    if (t > 9 || o > 9 || d > mx) return up ? 8'h00 : to_bcd(mx);
    d = up ? (d == mx ? 0 : d + 1) : (d == 0 ? mx : d - 1);
    return to_bcd(d);
  endfunction

  task automatic model_reset();
    m_state = 0; m_k = 0; m_idle = 0; m_run = 1'b1; m_load = 1'b0;
    m_h = 8'h00; m_m = 8'h00; m_s = 8'h00;
  endtask

  task automatic model_edge(bit bm, bit bi, bit bd);
    bit to;
    to = 1'b0;
    m_load = 1'b0;
    if (m_state == 0) begin
      m_k = 0;
      if (bm) begin
        m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
        m_state = 1; m_run = 1'b0; m_idle = 0;
      end
    end else begin
`ifdef CLKSET_TIMEOUT_EN
      if (bm || bi || bd) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) to = 1'b1;
      end
`endif
      if (to) begin
        m_state = 0; m_run = 1'b1; m_k = 0; m_idle = 0;
      end else if (bm && m_state == 3) begin
        m_state = 0; m_load = 1'b1; m_run = 1'b1; m_k = 0;
      end else begin
        if (bm) m_state++;
        else if (bi != bd) begin
          if (m_state == 1) m_h = step(m_h, 23, bi);
          else if (m_state == 2) m_m = step(m_m, 59, bi);
          else m_s = step(m_s, 59, bi);
        end
        m_k = (bi || bd) ? 0 : m_k + 1;
      end
    end
  endtask

  task automatic check_model();
    chk("mdl_mode", 8'(mode), 8'(m_state));
    chk("mdl_run_en", 8'(run_en), 8'(m_run));
    chk("mdl_load", 8'(load), 8'(m_load));
    chk("mdl_hour", set_hour, m_h);
    chk("mdl_min", set_min, m_m);
    chk("mdl_sec", set_sec, m_s);
    chk("mdl_sel", 8'(blink_sel), m_state == 1 ? 8'h04 : m_state == 2 ? 8'h02 : m_state == 3 ? 8'h01 : 8'h00);
    chk("mdl_phase", 8'(blink_phase), 8'((m_k / BLINK_DIV) % 2));
  endtask

  task automatic tick(bit bm, bit bi, bit bd);
    btn_mode = bm; btn_inc = bi; btn_dec = bd;
    @(posedge clkinput);
    model_edge(bm, bi, bd);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    check_model();
  endtask

  typedef struct {
    logic       bm, bi, bd;
    logic [7:0] ch, cm, cs;
    logic [1:0] em;
    logic       er, el;
    logic [7:0] eh, emi, es;
    logic [2:0] esel;
  } vec_t;
  vec_t vecs[29];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1,1'b0,1'b0, 8'h12,8'h34,8'h56, 2'd1,1'b0,1'b0, 8'h12,8'h34,8'h56, 3'b100};
    vecs[1]  = '{1'b1,1'b1,1'b0, 8'h12,8'h34,8'h56, 2'd2,1'b0,1'b0, 8'h12,8'h34,8'h56, 3'b010};
    vecs[2]  = '{1'b0,1'b1,1'b1, 8'h12,8'h34,8'h56, 2'd2,1'b0,1'b0, 8'h12,8'h34,8'h56, 3'b010};
    vecs[3]  = '{1'b1,1'b0,1'b0, 8'h12,8'h34,8'h56, 2'd3,1'b0,1'b0, 8'h12,8'h34,8'h56, 3'b001};
    vecs[4]  = '{1'b1,1'b0,1'b0, 8'h12,8'h34,8'h56, 2'd0,1'b1,1'b1, 8'h12,8'h34,8'h56, 3'b000};
    vecs[5]  = '{1'b0,1'b0,1'b0, 8'h12,8'h34,8'h56, 2'd0,1'b1,1'b0, 8'h12,8'h34,8'h56, 3'b000};
    vecs[6]  = '{1'b1,1'b0,1'b0, 8'h23,8'h00,8'h09, 2'd1,1'b0,1'b0, 8'h23,8'h00,8'h09, 3'b100};
    vecs[7]  = '{1'b0,1'b1,1'b0, 8'h23,8'h00,8'h09, 2'd1,1'b0,1'b0, 8'h00,8'h00,8'h09, 3'b100};
    vecs[8]  = '{1'b0,1'b0,1'b1, 8'h23,8'h00,8'h09, 2'd1,1'b0,1'b0, 8'h23,8'h00,8'h09, 3'b100};
    vecs[9]  = '{1'b1,1'b0,1'b0, 8'h23,8'h00,8'h09, 2'd2,1'b0,1'b0, 8'h23,8'h00,8'h09, 3'b010};
    vecs[10] = '{1'b0,1'b0,1'b1, 8'h23,8'h00,8'h09, 2'd2,1'b0,1'b0, 8'h23,8'h59,8'h09, 3'b010};
    vecs[11] = '{1'b0,1'b1,1'b0, 8'h23,8'h00,8'h09, 2'd2,1'b0,1'b0, 8'h23,8'h00,8'h09, 3'b010};
    vecs[12] = '{1'b1,1'b0,1'b0, 8'h23,8'h00,8'h09, 2'd3,1'b0,1'b0, 8'h23,8'h00,8'h09, 3'b001};
    vecs[13] = '{1'b0,1'b1,1'b0, 8'h23,8'h00,8'h09, 2'd3,1'b0,1'b0, 8'h23,8'h00,8'h10, 3'b001};
    vecs[14] = '{1'b0,1'b0,1'b1, 8'h23,8'h00,8'h09, 2'd3,1'b0,1'b0, 8'h23,8'h00,8'h09, 3'b001};
    vecs[15] = '{1'b0,1'b0,1'b1, 8'h23,8'h00,8'h09, 2'd3,1'b0,1'b0, 8'h23,8'h00,8'h08, 3'b001};
    vecs[16] = '{1'b1,1'b0,1'b0, 8'h23,8'h00,8'h09, 2'd0,1'b1,1'b1, 8'h23,8'h00,8'h08, 3'b000};
    vecs[17] = '{1'b0,1'b1,1'b0, 8'h23,8'h00,8'h09, 2'd0,1'b1,1'b0, 8'h23,8'h00,8'h08, 3'b000};
    vecs[18] = '{1'b1,1'b0,1'b0, 8'h2A,8'h00,8'h00, 2'd1,1'b0,1'b0, 8'h2A,8'h00,8'h00, 3'b100};
    vecs[19] = '{1'b0,1'b0,1'b1, 8'h2A,8'h00,8'h00, 2'd1,1'b0,1'b0, 8'h23,8'h00,8'h00, 3'b100};
    vecs[20] = '{1'b1,1'b0,1'b0, 8'h2A,8'h00,8'h00, 2'd2,1'b0,1'b0, 8'h23,8'h00,8'h00, 3'b010};
    vecs[21] = '{1'b0,1'b1,1'b0, 8'h2A,8'h00,8'h00, 2'd2,1'b0,1'b0, 8'h23,8'h01,8'h00, 3'b010};
    vecs[22] = '{1'b1,1'b0,1'b0, 8'h2A,8'h00,8'h00, 2'd3,1'b0,1'b0, 8'h23,8'h01,8'h00, 3'b001};
    vecs[23] = '{1'b1,1'b0,1'b0, 8'h2A,8'h00,8'h00, 2'd0,1'b1,1'b1, 8'h23,8'h01,8'h00, 3'b000};
    vecs[24] = '{1'b1,1'b0,1'b0, 8'h00,8'h7F,8'h00, 2'd1,1'b0,1'b0, 8'h00,8'h7F,8'h00, 3'b100};
    vecs[25] = '{1'b1,1'b0,1'b0, 8'h00,8'h7F,8'h00, 2'd2,1'b0,1'b0, 8'h00,8'h7F,8'h00, 3'b010};
    vecs[26] = '{1'b0,1'b1,1'b0, 8'h00,8'h7F,8'h00, 2'd2,1'b0,1'b0, 8'h00,8'h00,8'h00, 3'b010};
    vecs[27] = '{1'b1,1'b0,1'b0, 8'h00,8'h7F,8'h00, 2'd3,1'b0,1'b0, 8'h00,8'h00,8'h00, 3'b001};
    vecs[28] = '{1'b1,1'b0,1'b0, 8'h00,8'h7F,8'h00, 2'd0,1'b1,1'b1, 8'h00,8'h00,8'h00, 3'b000};

    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cur_hour = 8'h00; cur_min = 8'h00; cur_sec = 8'h00;
    model_reset();
    repeat (3) @(posedge clkinput);
    #1;
    chk("rst_mode", 8'(mode), 8'h00);
    chk("rst_run_en", 8'(run_en), 8'h01);
    chk("rst_load", 8'(load), 8'h00);
    chk("rst_hour", set_hour, 8'h00);
    chk("rst_min", set_min, 8'h00);
    chk("rst_sec", set_sec, 8'h00);
    chk("rst_sel", 8'(blink_sel), 8'h00);
    chk("rst_phase", 8'(blink_phase), 8'h00);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 29; i++) begin
      cur_hour = vecs[i].ch; cur_min = vecs[i].cm; cur_sec = vecs[i].cs;
      tick(vecs[i].bm, vecs[i].bi, vecs[i].bd);
      chk($sformatf("vec%0d_mode", i), 8'(mode), 8'(vecs[i].em));
      chk($sformatf("vec%0d_run_en", i), 8'(run_en), 8'(vecs[i].er));
      chk($sformatf("vec%0d_load", i), 8'(load), 8'(vecs[i].el));
      chk($sformatf("vec%0d_hour", i), set_hour, vecs[i].eh);
      chk($sformatf("vec%0d_min", i), set_min, vecs[i].emi);
      chk($sformatf("vec%0d_sec", i), set_sec, vecs[i].es);
      chk($sformatf("vec%0d_sel", i), 8'(blink_sel), 8'(vecs[i].esel));
    end

    tick(1'b1, 1'b0, 1'b0);
    repeat (BLINK_DIV - 1) tick(1'b0, 1'b0, 1'b0);
    chk("blink_before_toggle", 8'(blink_phase), 8'h00);
    tick(1'b0, 1'b0, 1'b0);
    chk("blink_toggled", 8'(blink_phase), 8'h01);
    tick(1'b0, 1'b1, 1'b0);
    chk("blink_cleared_by_inc", 8'(blink_phase), 8'h00);
    repeat (3) tick(1'b1, 1'b0, 1'b0);

    cur_hour = 8'h00; cur_min = 8'h45; cur_sec = 8'h00;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("midedit_min", set_min, 8'h45);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst_mode", 8'(mode), 8'h00);
    chk("arst_run_en", 8'(run_en), 8'h01);
    chk("arst_load", 8'(load), 8'h00);
    chk("arst_min", set_min, 8'h00);
    chk("arst_sel", 8'(blink_sel), 8'h00);
    @(posedge clkinput);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk("arst_no_load", 8'(load), 8'h00);
    end

    repeat (3) tick(1'b1, 1'b0, 1'b0);
`ifdef CLKSET_TIMEOUT_EN
    repeat (TIMEOUT_CYC - 1) tick(1'b0, 1'b0, 1'b0);
    chk("to_not_yet", 8'(mode), 8'h03);
    tick(1'b0, 1'b0, 1'b0);
    chk("to_mode", 8'(mode), 8'h00);
    chk("to_run_en", 8'(run_en), 8'h01);
    chk("to_no_load", 8'(load), 8'h00);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    repeat (TIMEOUT_CYC - 2) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    repeat (TIMEOUT_CYC - 1) tick(1'b0, 1'b0, 1'b0);
    chk("to_restart_held", 8'(mode), 8'h03);
    tick(1'b0, 1'b0, 1'b0);
    chk("to_restart_expired", 8'(mode), 8'h00);
    chk("to_restart_no_load", 8'(load), 8'h00);
`else
    repeat (150) tick(1'b0, 1'b0, 1'b0);
    chk("no_timeout_hold", 8'(mode), 8'h03);
    tick(1'b1, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        cur_hour = to_bcd(int'($urandom_range(0, 23)));
        cur_min  = to_bcd(int'($urandom_range(0, 59)));
        cur_sec  = to_bcd(int'($urandom_range(0, 59)));
      end else begin
        cur_hour = 8'($urandom); cur_min = 8'($urandom); cur_sec = 8'($urandom);
      end
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
